edge_detect_frame_ctrl: RTL and testbench

// Frame sequencer for the edge-detect pipeline (input FIFO -> grayscale -> sobel -> output FIFO).

---
 rtl/edge_detect_pkg.sv | 17 +
 rtl/edge_detect_watchdog.sv | 29 ++
 rtl/edge_detect_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_edge_detect_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared types and constants for the edge-detect frame sequencer.
package edge_detect_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int DATA_WIDTH_DEFAULT = 24;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/edge_detect_watchdog.sv
// Drain-stall watchdog: counts consecutive enabled cycles without a kick and
// flags expiry on the TIMEOUT-th idle cycle.
module edge_detect_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic kick,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

   logic [W-1:0] idle_cnt;

   // idle_cnt holds the number of completed idle cycles before the current one
   always_ff @(posedge clock) begin
      if (reset || !enable || kick) begin
         idle_cnt <= '0;
      end else if (idle_cnt != LIMIT) begin
         idle_cnt <= idle_cnt + W'(1);
      end
   end

   assign expire = enable && !kick && (idle_cnt == LIMIT);

endmodule

// File: rtl/edge_detect_frame_ctrl.sv
// Frame sequencer: feeds width*height pixels into the pipeline, drains the
// same number of results to the host sink, then reports done or aborts.
module edge_detect_frame_ctrl
   import edge_detect_pkg::*;
#(
   parameter int  DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int  MAX_WIDTH  = 1024,
   parameter int  MAX_HEIGHT = 1024,
   parameter int  TIMEOUT    = 4096,
   localparam int DIM_BITS   = $clog2(max_int(MAX_WIDTH, MAX_HEIGHT) + 1),
   localparam int CNT_BITS   = $clog2(MAX_WIDTH * MAX_HEIGHT + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIM_BITS-1:0]   img_width,
   input  logic [DIM_BITS-1:0]   img_height,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  cfg_err,
   output logic                  timeout,
   input  logic                  src_empty,
   output logic                  src_rd_en,
   input  logic [DATA_WIDTH-1:0] src_dout,
   input  logic                  pipe_full,
   output logic                  pipe_wr_en,
   output logic [DATA_WIDTH-1:0] pipe_din,
   input  logic                  res_empty,
   output logic                  res_rd_en,
   input  logic [DATA_WIDTH-1:0] res_dout,
   input  logic                  snk_full,
   output logic                  snk_wr_en,
   output logic [DATA_WIDTH-1:0] snk_din,
   output logic [CNT_BITS-1:0]   in_count,
   output logic [CNT_BITS-1:0]   out_count
);

   localparam logic [DIM_BITS-1:0] MAX_W   = DIM_BITS'(MAX_WIDTH);
   localparam logic [DIM_BITS-1:0] MAX_H   = DIM_BITS'(MAX_HEIGHT);
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   state_t              state;
   state_t              next_state;
   logic [CNT_BITS-1:0] total;
   logic [CNT_BITS-1:0] in_next;
   logic [CNT_BITS-1:0] out_next;
   logic                dims_ok;
   logic                feed;
   logic                drain;
   logic                accept;
   logic                reject;
   logic                expire;

   assign dims_ok = (img_width != '0) && (img_width <= MAX_W) &&
                    (img_height != '0) && (img_height <= MAX_H);

   // Both transfers are purely combinational from the FIFO flags so a word
   // moves in the same cycle the handshake allows it.
   assign feed  = (state == S_RUN) && !src_empty && !pipe_full && (in_count < total);
   assign drain = ((state == S_RUN) || (state == S_DRAIN)) &&
                  !res_empty && !snk_full && (out_count < total);

   assign in_next  = feed  ? in_count  + CNT_ONE : in_count;
   assign out_next = drain ? out_count + CNT_ONE : out_count;

   assign src_rd_en  = feed;
   assign pipe_wr_en = feed;
   assign res_rd_en  = drain;
   assign snk_wr_en  = drain;
   assign pipe_din   = src_dout;
   assign snk_din    = res_dout;

   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

   edge_detect_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clock (clock),
      .reset (reset),
      .enable(state == S_DRAIN),
      .kick  (drain),
      .expire(expire)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Completion of the drain side wins over feed completion, so a frame whose
   // last input and last result move together goes straight to DONE.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      reject     = 1'b0;
      timeout    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (dims_ok) begin
                  accept     = 1'b1;
                  next_state = S_RUN;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (out_next == total) begin
               next_state = S_DONE;
            end else if (in_next == total) begin
               next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_next == total) begin
               next_state = S_DONE;
            end else if (expire) begin
               timeout    = 1'b1;
               next_state = S_IDLE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Counts survive done/abort so the host can inspect them until the next
   // accepted start clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         total     <= '0;
         in_count  <= '0;
         out_count <= '0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= reject;
         if (accept) begin
            total     <= CNT_BITS'(img_width) * CNT_BITS'(img_height);
            in_count  <= '0;
            out_count <= '0;
         end else begin
            in_count  <= in_next;
            out_count <= out_next;
         end
      end
   end

endmodule

// File: tb/tb_edge_detect_frame_ctrl.sv
// Directed bench for edge_detect_frame_ctrl: normal frames, back-pressure,
// config errors, drain timeout, ignored restart and mid-frame reset.
module tb_edge_detect_frame_ctrl;

   localparam int DW   = 24;
   localparam int DIMB = 11;
   localparam int CNTB = 21;

   logic            clock = 1'b0;
   logic            reset;
   logic            start;
   logic [DIMB-1:0] img_width;
   logic [DIMB-1:0] img_height;
   logic            busy;
   logic            frame_done;
   logic            cfg_err;
   logic            timeout;
   logic            src_empty;
   logic            src_rd_en;
   logic [DW-1:0]   src_dout;
   logic            pipe_full;
   logic            pipe_wr_en;
   logic [DW-1:0]   pipe_din;
   logic            res_empty;
   logic            res_rd_en;
   logic [DW-1:0]   res_dout;
   logic            snk_full;
   logic            snk_wr_en;
   logic [DW-1:0]   snk_din;
   logic [CNTB-1:0] in_count;
   logic [CNTB-1:0] out_count;

   int checks = 0;
   int errors = 0;

   int src_pops = 0, snk_pops = 0, done_cnt = 0, to_cnt = 0, cfg_cnt = 0, viol_cnt = 0;
   int b_src, b_snk, b_done, b_to, b_cfg, b_viol;

   edge_detect_frame_ctrl #(
      .DATA_WIDTH(DW),
      .MAX_WIDTH (1024),
      .MAX_HEIGHT(1024),
      .TIMEOUT   (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .img_width (img_width),
      .img_height(img_height),
      .busy      (busy),
      .frame_done(frame_done),
      .cfg_err   (cfg_err),
      .timeout   (timeout),
      .src_empty (src_empty),
      .src_rd_en (src_rd_en),
      .src_dout  (src_dout),
      .pipe_full (pipe_full),
      .pipe_wr_en(pipe_wr_en),
      .pipe_din  (pipe_din),
      .res_empty (res_empty),
      .res_rd_en (res_rd_en),
      .res_dout  (res_dout),
      .snk_full  (snk_full),
      .snk_wr_en (snk_wr_en),
      .snk_din   (snk_din),
      .in_count  (in_count),
      .out_count (out_count)
   );

   always #5 clock = ~clock;

   assign src_dout = 24'h100000 + src_pops[23:0];
   assign res_dout = 24'hA00000 + res_pops_lo();

   function automatic logic [23:0] res_pops_lo();
      return snk_pops[23:0];
   endfunction

   // Transfer and pulse bookkeeping, plus handshake rule violations
   always @(posedge clock) begin
      if (!reset) begin
         if (pipe_wr_en) src_pops <= src_pops + 1;
         if (snk_wr_en)  snk_pops <= snk_pops + 1;
         if (frame_done) done_cnt <= done_cnt + 1;
         if (timeout)    to_cnt   <= to_cnt + 1;
         if (cfg_err)    cfg_cnt  <= cfg_cnt + 1;
         if ((src_rd_en && src_empty) || (pipe_wr_en && pipe_full) ||
             (res_rd_en && res_empty) || (snk_wr_en && snk_full) ||
             (src_rd_en != pipe_wr_en) || (res_rd_en != snk_wr_en))
            viol_cnt <= viol_cnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input int w, input int h);
      start      = st;
      img_width  = DIMB'(w);
      img_height = DIMB'(h);
   endtask

   task automatic snap();
      b_src = src_pops; b_snk = snk_pops; b_done = done_cnt;
      b_to = to_cnt; b_cfg = cfg_cnt; b_viol = viol_cnt;
   endtask

   initial begin
      int lat;
      int snk_at20;
      int busy22;
      int busy24;

      reset = 1'b1;
      applyStimulus(1'b0, 0, 0);
      src_empty = 1'b0;
      res_empty = 1'b0;
      pipe_full = 1'b0;
      snk_full  = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", frame_done, 0);
      checkOutput("rst_cfg", cfg_err, 0);
      checkOutput("rst_timeout", timeout, 0);
      checkOutput("rst_src_rd", src_rd_en, 0);
      checkOutput("rst_snk_wr", snk_wr_en, 0);
      checkOutput("rst_in_count", in_count, 0);
      checkOutput("rst_out_count", out_count, 0);
      reset = 1'b0;
      @(negedge clock);

      // 4x3 with free-flowing FIFOs
      snap();
      applyStimulus(1'b1, 4, 3);
      @(negedge clock);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t1_busy", busy, 1);
      checkOutput("t1_pipe_din", pipe_din, 32'h100000 + src_pops);
      checkOutput("t1_snk_din", snk_din, 32'hA00000 + snk_pops);
      lat = -1;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clock);
         if (frame_done && lat < 0) lat = k;
      end
      checkOutput("t1_done_latency", lat, 13);
      checkOutput("t1_pipe_pushes", src_pops - b_src, 12);
      checkOutput("t1_sink_pushes", snk_pops - b_snk, 12);
      checkOutput("t1_done_pulses", done_cnt - b_done, 1);
      checkOutput("t1_in_count", in_count, 12);
      checkOutput("t1_out_count", out_count, 12);
      checkOutput("t1_busy_after", busy, 0);

      // 4x3 with pipeline back-pressure and a stalled sink
      snap();
      snk_full = 1'b1;
      applyStimulus(1'b1, 4, 3);
      snk_at20 = -1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clock);
         if (k == 1) applyStimulus(1'b0, 0, 0);
         if (k == 20) snk_at20 = snk_pops - b_snk;
         pipe_full = ((k / 2) % 2) == 1;
         snk_full  = (k < 20);
      end
      pipe_full = 1'b0;
      snk_full  = 1'b0;
      checkOutput("t2_sink_while_full", snk_at20, 0);
      checkOutput("t2_pipe_pushes", src_pops - b_src, 12);
      checkOutput("t2_sink_pushes", snk_pops - b_snk, 12);
      checkOutput("t2_done_pulses", done_cnt - b_done, 1);
      checkOutput("t2_timeouts", to_cnt - b_to, 0);
      checkOutput("t2_in_count", in_count, 12);
      checkOutput("t2_out_count", out_count, 12);

      // Configuration errors
      snap();
      applyStimulus(1'b1, 0, 3);
      @(negedge clock);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t3_cfg_w0", cfg_err, 1);
      checkOutput("t3_busy_w0", busy, 0);
      @(negedge clock);
      checkOutput("t3_cfg_w0_end", cfg_err, 0);
      applyStimulus(1'b1, 1025, 1);
      @(negedge clock);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t3_cfg_wbig", cfg_err, 1);
      checkOutput("t3_busy_wbig", busy, 0);
      @(negedge clock);
      checkOutput("t3_cfg_wbig_end", cfg_err, 0);
      checkOutput("t3_cfg_pulses", cfg_cnt - b_cfg, 2);
      checkOutput("t3_in_count_held", in_count, 12);

      // 2x2 with results stalling after the third
      snap();
      res_empty = 1'b1;
      applyStimulus(1'b1, 2, 2);
      lat = -1; busy22 = -1; busy24 = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         if (k == 1) applyStimulus(1'b0, 0, 0);
         if (k == 5) res_empty = 1'b0;
         if (k == 8) res_empty = 1'b1;
         if (timeout && lat < 0) lat = k;
         if (k == 22) busy22 = busy;
         if (k == 24) busy24 = busy;
      end
      checkOutput("t4_timeout_latency", lat, 23);
      checkOutput("t4_busy_stalled", busy22, 1);
      checkOutput("t4_busy_after", busy24, 0);
      checkOutput("t4_timeout_pulses", to_cnt - b_to, 1);
      checkOutput("t4_done_pulses", done_cnt - b_done, 0);
      checkOutput("t4_pipe_pushes", src_pops - b_src, 4);
      checkOutput("t4_sink_pushes", snk_pops - b_snk, 3);
      checkOutput("t4_in_count", in_count, 4);
      checkOutput("t4_out_count", out_count, 3);

      // Restart request during a frame must be ignored
      snap();
      res_empty = 1'b0;
      applyStimulus(1'b1, 4, 3);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 1) applyStimulus(1'b0, 0, 0);
         if (k == 3) applyStimulus(1'b1, 8, 8);
         if (k == 4) applyStimulus(1'b0, 0, 0);
         if (frame_done && lat < 0) lat = k;
      end
      checkOutput("t5_done_latency", lat, 13);
      checkOutput("t5_pipe_pushes", src_pops - b_src, 12);
      checkOutput("t5_sink_pushes", snk_pops - b_snk, 12);
      checkOutput("t5_cfg_pulses", cfg_cnt - b_cfg, 0);
      checkOutput("t5_in_count", in_count, 12);

      // Reset in the middle of RUN
      snap();
      res_empty = 1'b1;
      applyStimulus(1'b1, 4, 3);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         if (k == 1) applyStimulus(1'b0, 0, 0);
      end
      @(negedge clock);
      checkOutput("t6_in_before_reset", in_count, 5);
      res_empty = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_src_rd", src_rd_en, 0);
      checkOutput("t6_pipe_wr", pipe_wr_en, 0);
      checkOutput("t6_res_rd", res_rd_en, 0);
      checkOutput("t6_snk_wr", snk_wr_en, 0);
      checkOutput("t6_in_count", in_count, 0);
      checkOutput("t6_out_count", out_count, 0);
      checkOutput("t6_done", frame_done, 0);
      checkOutput("t6_timeout", timeout, 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checkOutput("t6_busy_idle", busy, 0);
      checkOutput("t6_done_pulses", done_cnt - b_done, 0);
      checkOutput("t6_timeout_pulses", to_cnt - b_to, 0);
      checkOutput("handshake_violations", viol_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
